// File: rtl/ro_puf_pkg.sv
// +--------------------------------------------------------------------+
// | ro_puf_pkg : shared FSM encoding, timing constants and LFSR helpers  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package ro_puf_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEED    = 3'd1,
    SETTLE  = 3'd2,
    MEASURE = 3'd3,
    VOTE    = 3'd4,
    SHIFT   = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam int SETTLE_CYC = 4;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Fibonacci tap masks (bit n-1 set for polynomial term x^n), maximal-length where listed
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      16:      return 32'h0000_D008;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0003 << (w - 2);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ro_puf_engine_if.sv
// +--------------------------------------------------------------------+
// | ro_puf_engine_if : run request / response bus of the RO-PUF engine   |
// | Optional unstable_mask present with RO_PUF_UNSTABLE_MASK_EN. Rev 1.0  |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface ro_puf_engine_if #(
  parameter int CHAL_W = 8,
  parameter int RESP_W = 256
);
  logic              start;
  logic [CHAL_W-1:0] challenge;
  logic              busy;
  logic              done;
  logic [RESP_W-1:0] response;
  logic              response_valid;
`ifdef RO_PUF_UNSTABLE_MASK_EN
  logic [RESP_W-1:0] unstable_mask;
`endif

  modport master (
    output start, challenge,
    input
`ifdef RO_PUF_UNSTABLE_MASK_EN
          unstable_mask,
`endif
          busy, done, response, response_valid
  );

  modport slave (
    input  start, challenge,
    output
`ifdef RO_PUF_UNSTABLE_MASK_EN
           unstable_mask,
`endif
           busy, done, response, response_valid
  );
endinterface

`default_nettype wire

// File: rtl/ro_edge_counter.sv
// +--------------------------------------------------------------------+
// | ro_edge_counter : per-bank 2-flop sync, post-sync select, rising-edge |
// | detect and saturating edge counter. Rev 1.0                          |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module ro_edge_counter #(
  parameter int N_RO  = 16,
  parameter int SEL_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_RO-1:0]  ro,
  input  logic [SEL_W-1:0] sel,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [N_RO-1:0] sync_1;
  logic [N_RO-1:0] sync_2;
  logic            prev;
  logic            cur;

  assign cur = sync_2[sel];

  // prev always tracks the selected line so a select change never looks like an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
      prev   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_1 <= ro;
      sync_2 <= sync_1;
      prev   <= cur;
      if (clr) begin
        cnt <= '0;
      end else if (en && cur && !prev && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ro_puf_engine.sv
// +--------------------------------------------------------------------+
// | ro_puf_engine : LFSR-driven RO-pair measurement with majority vote.   |
// | Optional RO_PUF_UNSTABLE_MASK_EN adds unstable_mask. Rev 1.0          |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module ro_puf_engine
  import ro_puf_pkg::*;
#(
  parameter int N_RO    = 16,
  parameter int CHAL_W  = 8,
  parameter int RESP_W  = 256,
  parameter int CNT_W   = 16,
  parameter int WIN_CYC = 256,
  parameter int N_VOTE  = 3,
  parameter int MARGIN  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_RO-1:0] ro_a,
  input  logic [N_RO-1:0] ro_b,
  output logic            ro_en,
  ro_puf_engine_if.slave  bus
);

  localparam int SEL_W  = clog2(N_RO);
  localparam int BIT_W  = (RESP_W > 1) ? clog2(RESP_W) : 1;
  localparam int VC_W   = (N_VOTE > 1) ? clog2(N_VOTE) : 1;
  localparam int ONES_W = clog2(N_VOTE + 1);
  localparam int CYC_MX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int CYC_W  = (CYC_MX > 1) ? clog2(CYC_MX) : 1;
  localparam logic [CHAL_W-1:0] TAPS = CHAL_W'(lfsr_taps(CHAL_W));

  state_t             state;
  state_t             next_state;
  logic [CYC_W-1:0]   cyc;
  logic [CHAL_W-1:0]  chal_q;
  logic [CHAL_W-1:0]  lfsr;
  logic [BIT_W-1:0]   bit_idx;
  logic [VC_W-1:0]    vote_cnt;
  logic [ONES_W-1:0]  ones;
  logic [RESP_W-1:0]  response_q;
  logic               response_valid_q;
  logic               done_q;
  logic               busy_c;
  logic               cnt_clr;
  logic               cnt_en;
  logic [SEL_W-1:0]   sel_a;
  logic [SEL_W-1:0]   sel_b;
  logic [CNT_W-1:0]   cnt_a;
  logic [CNT_W-1:0]   cnt_b;
  logic               vote;
  logic               last_vote;
  logic               last_bit;
  logic               accept;

  assign sel_a     = lfsr[SEL_W-1:0];
  assign sel_b     = lfsr[2*SEL_W-1:SEL_W];
  assign vote      = (cnt_a > cnt_b);
  assign last_vote = (vote_cnt == VC_W'(N_VOTE - 1));
  assign last_bit  = (bit_idx == BIT_W'(RESP_W - 1));
  assign accept    = (state == IDLE) && bus.start;

  ro_edge_counter #(.N_RO(N_RO), .SEL_W(SEL_W), .CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .reset (reset),
    .ro    (ro_a),
    .sel   (sel_a),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt_a)
  );

  ro_edge_counter #(.N_RO(N_RO), .SEL_W(SEL_W), .CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .reset (reset),
    .ro    (ro_b),
    .sel   (sel_b),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = SEED;
      SEED:    next_state = SETTLE;
      SETTLE:  if (cyc == CYC_W'(SETTLE_CYC - 1)) next_state = MEASURE;
      MEASURE: if (cyc == CYC_W'(WIN_CYC - 1)) next_state = VOTE;
      VOTE:    next_state = last_vote ? SHIFT : SETTLE;
      SHIFT:   next_state = last_bit ? DONE : SETTLE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ro_en   = 1'b0;
    busy_c  = (state != IDLE);
    cnt_clr = (state == SETTLE);
    cnt_en  = (state == MEASURE);
    case (state)
      SETTLE, MEASURE, VOTE, SHIFT: ro_en = 1'b1;
      default:                      ro_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc              <= '0;
      chal_q           <= '0;
      lfsr             <= CHAL_W'(1);
      bit_idx          <= '0;
      vote_cnt         <= '0;
      ones             <= '0;
      response_q       <= '0;
      response_valid_q <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      if ((next_state != state) || !((state == SETTLE) || (state == MEASURE))) cyc <= '0;
      else                                                                    cyc <= cyc + 1'b1;
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            chal_q           <= bus.challenge;
            response_q       <= '0;
            response_valid_q <= 1'b0;
            bit_idx          <= '0;
            vote_cnt         <= '0;
            ones             <= '0;
          end
        end
        // an all-zero seed would lock the LFSR
        SEED: lfsr <= (chal_q == '0) ? CHAL_W'(1) : chal_q;
        VOTE: begin
          ones     <= ones + ONES_W'(vote);
          vote_cnt <= last_vote ? '0 : vote_cnt + 1'b1;
        end
        SHIFT: begin
          response_q[bit_idx] <= (ones > ONES_W'(N_VOTE / 2));
          lfsr                <= {lfsr[CHAL_W-2:0], ^(lfsr & TAPS)};
          ones                <= '0;
          if (!last_bit) bit_idx <= bit_idx + 1'b1;
        end
        DONE: response_valid_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.busy           = busy_c;
  assign bus.done           = done_q;
  assign bus.response       = response_q;
  assign bus.response_valid = response_valid_q;

`ifdef RO_PUF_UNSTABLE_MASK_EN
  logic [RESP_W-1:0] mask_q;
  logic              weak;
  logic [CNT_W-1:0]  diff;

  assign diff = (cnt_a > cnt_b) ? (cnt_a - cnt_b) : (cnt_b - cnt_a);

  // a bit is unstable if any vote was close or the votes disagreed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      weak   <= 1'b0;
    end else if (accept) begin
      mask_q <= '0;
      weak   <= 1'b0;
    end else if (state == VOTE) begin
      weak <= weak | (32'(diff) < 32'(MARGIN));
    end else if (state == SHIFT) begin
      mask_q[bit_idx] <= weak | ((ones != '0) && (ones != ONES_W'(N_VOTE)));
      weak            <= 1'b0;
    end
  end

  assign bus.unstable_mask = mask_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ro_puf_engine.sv
// +--------------------------------------------------------------------+
// | tb_ro_puf_engine : scoreboard bench for ro_puf_engine (3 configs).    |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_ro_puf_engine;

  localparam int LIMIT = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ro_a;
  logic [15:0] ro_b;
  logic        ro_en1, ro_en2, ro_en3;
  int          per_a[16] = '{default: 4};
  int          per_b[16] = '{default: 4};
  int          ca[16] = '{default: 0};
  int          cb[16] = '{default: 0};
  int          total = 0;
  int          bad = 0;
  int          sel = 0;
  logic        start_r = 1'b0;
  logic [7:0]  chal_r = 8'h00;
  logic        o_busy, o_done, o_valid, o_ro_en;
  logic [7:0]  o_resp, o_mask;

  typedef struct {
    string      tag;
    logic [7:0] resp;
    logic [7:0] mask;
    bit         use_mask;
    int         lat;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  ro_puf_engine_if #(.CHAL_W(8), .RESP_W(8)) bus1 ();
  ro_puf_engine_if #(.CHAL_W(8), .RESP_W(8)) bus2 ();
  ro_puf_engine_if #(.CHAL_W(8), .RESP_W(8)) bus3 ();

  assign bus1.start = start_r && (sel == 0);
  assign bus2.start = start_r && (sel == 1);
  assign bus3.start = start_r && (sel == 2);
  assign bus1.challenge = chal_r;
  assign bus2.challenge = chal_r;
  assign bus3.challenge = chal_r;

  ro_puf_engine #(.N_RO(16), .CHAL_W(8), .RESP_W(8), .CNT_W(16), .WIN_CYC(32),
                  .N_VOTE(1), .MARGIN(4)) u_v1 (
    .clk(clk), .reset(reset), .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en1), .bus(bus1.slave));

  ro_puf_engine #(.N_RO(16), .CHAL_W(8), .RESP_W(8), .CNT_W(16), .WIN_CYC(32),
                  .N_VOTE(3), .MARGIN(4)) u_v3 (
    .clk(clk), .reset(reset), .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en2), .bus(bus2.slave));

  ro_puf_engine #(.N_RO(16), .CHAL_W(8), .RESP_W(8), .CNT_W(4), .WIN_CYC(80),
                  .N_VOTE(1), .MARGIN(4)) u_sat (
    .clk(clk), .reset(reset), .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en3), .bus(bus3.slave));

  always_comb begin
    o_busy = 1'b0; o_done = 1'b0; o_valid = 1'b0; o_ro_en = 1'b0;
    o_resp = 8'h00; o_mask = 8'h00;
    case (sel)
      0: begin
        o_busy = bus1.busy; o_done = bus1.done; o_valid = bus1.response_valid;
        o_resp = bus1.response; o_ro_en = ro_en1;
`ifdef RO_PUF_UNSTABLE_MASK_EN
        o_mask = bus1.unstable_mask;
`endif
      end
      1: begin
        o_busy = bus2.busy; o_done = bus2.done; o_valid = bus2.response_valid;
        o_resp = bus2.response; o_ro_en = ro_en2;
`ifdef RO_PUF_UNSTABLE_MASK_EN
        o_mask = bus2.unstable_mask;
`endif
      end
      default: begin
        o_busy = bus3.busy; o_done = bus3.done; o_valid = bus3.response_valid;
        o_resp = bus3.response; o_ro_en = ro_en3;
`ifdef RO_PUF_UNSTABLE_MASK_EN
        o_mask = bus3.unstable_mask;
`endif
      end
    endcase
  end

  // each RO line toggles every per_* negedges
  initial begin
    ro_a = '0;
    ro_b = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        if (ca[i] >= per_a[i] - 1) begin ca[i] = 0; ro_a[i] = ~ro_a[i]; end
        else ca[i] = ca[i] + 1;
        if (cb[i] >= per_b[i] - 1) begin cb[i] = 0; ro_b[i] = ~ro_b[i]; end
        else cb[i] = cb[i] + 1;
      end
    end
  end

  task automatic set_banks(input int a_even, input int a_odd, input int b);
    for (int i = 0; i < 16; i++) begin
      per_a[i] = (i % 2 == 0) ? a_even : a_odd;
      per_b[i] = b;
      ca[i] = 0;
      cb[i] = 0;
    end
    ro_a = '0;
    ro_b = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // even sel_a -> fast A line wins, so bit k = ~lfsr[0]
  function automatic logic [7:0] model_resp(input logic [7:0] seed);
    logic [7:0] l;
    logic [7:0] r;
    l = (seed == 8'h00) ? 8'h01 : seed;
    r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      r[k] = ~l[0];
      l = {l[6:0], ^(l & 8'hB8)};
    end
    return r;
  endfunction

  function automatic int lat_of(input int d);
    int nv;
    int win;
    nv  = (d == 1) ? 3 : 1;
    win = (d == 2) ? 80 : 32;
    return 2 + 8 * (nv * (4 + win + 1) + 1);
  endfunction

  // bit 0, vote 1 (0-based) gets a slow bank A; votes 0 and 2 a fast one
  task automatic maj_pattern();
    repeat (37) @(posedge clk);
    #1 set_banks(16, 16, 8);
    repeat (37) @(posedge clk);
    #1 set_banks(2, 2, 8);
  endtask

  task automatic run(input int d, input logic [7:0] ch, input logic [7:0] er,
                     input logic [7:0] em, input bit um, input int busy_pulse,
                     input string tag);
    exp_t e;
    int   n;
    e.tag = tag; e.resp = er; e.mask = em; e.use_mask = um; e.lat = lat_of(d);
    sbq.push_back(e);
    sel = d;
    @(posedge clk); #1;
    chal_r  = ch;
    start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    chal_r  = ~ch;
    chk({tag, "_busy"}, 32'(o_busy), 32'd1);
    chk({tag, "_clr"}, {23'd0, o_valid, o_resp}, 32'd0);
    if (d == 1) fork maj_pattern(); join_none
    n = 0;
    while (!o_done && n < LIMIT) begin
      if (n == busy_pulse) start_r = 1'b1;
      @(posedge clk); #1;
      start_r = 1'b0;
      n = n + 1;
    end
    e = sbq.pop_front();
    chk({e.tag, "_done_seen"}, 32'(o_done), 32'd1);
    chk({e.tag, "_lat"}, 32'(n), 32'(e.lat));
    chk({e.tag, "_resp"}, 32'(o_resp), 32'(e.resp));
    chk({e.tag, "_valid"}, 32'(o_valid), 32'd1);
`ifdef RO_PUF_UNSTABLE_MASK_EN
    if (e.use_mask) chk({e.tag, "_mask"}, 32'(o_mask), 32'(e.mask));
`endif
    @(posedge clk); #1;
    chk({e.tag, "_done_pulse"}, 32'(o_done), 32'd0);
    chk({e.tag, "_idle"}, 32'(o_busy), 32'd0);
    chk({e.tag, "_hold"}, {23'd0, o_valid, o_resp}, {23'd0, 1'b1, e.resp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    set_banks(3, 3, 5);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {27'd0, o_busy, o_done, o_valid, o_ro_en, 1'b0}, 32'd0);
    chk("rst_resp", 32'(o_resp), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", 32'(o_busy), 32'd0);

    set_banks(3, 3, 5);
    run(0, 8'hA5, 8'hFF, 8'h00, 1'b0, -1, "det");
    set_banks(5, 5, 3);
    run(0, 8'hA5, 8'h00, 8'h00, 1'b0, -1, "rev");
    set_banks(4, 4, 4);
    run(0, 8'h3C, 8'h00, 8'hFF, 1'b1, -1, "tie");
    set_banks(2, 6, 4);
    run(0, 8'h00, model_resp(8'h00), 8'h00, 1'b0, -1, "zero_chal");
    run(0, 8'h01, model_resp(8'h01), 8'h00, 1'b0, -1, "one_chal");
    run(0, 8'hA5, model_resp(8'hA5), 8'h00, 1'b0, -1, "lfsr_a5");
    set_banks(3, 3, 5);
    run(0, 8'h5A, 8'hFF, 8'h00, 1'b0, 50, "start_busy");
    set_banks(2, 2, 8);
    run(1, 8'h77, 8'hFF, 8'h01, 1'b1, -1, "majority");
    set_banks(2, 2, 4);
    run(2, 8'h12, 8'hFF, 8'h00, 1'b0, -1, "saturate");

    // asynchronous reset in MEASURE
    sel = 0;
    set_banks(3, 3, 5);
    @(posedge clk); #1;
    chal_r = 8'hC3;
    start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_ro_en", 32'(o_ro_en), 32'd1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("mrst_busy_ro_en", {30'd0, o_busy, o_ro_en}, 32'd0);
    chk("mrst_resp", {23'd0, o_valid, o_resp}, 32'd0);
    chk("mrst_other_resp", {23'd0, bus3.response_valid, bus3.response}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_idle", {30'd0, o_busy, o_done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
